// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller: FSM encoding,
// bubble instruction and SRAM address formatting.
package imem_ctrl_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DM_RD  = 3'd1,
        ST_DM_WR1 = 3'd2,
        ST_DM_WR2 = 3'd3,
        ST_DM_WR3 = 3'd4
    } imem_state_e;

    localparam word_t NOP_INSTR_DEFAULT = 16'h0800;

    // The SRAM has 18 address bits; only the low 64K words are used.
    function automatic logic [17:0] ram_addr_fmt(input word_t addr);
        return {2'b00, addr};
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Data-side access port of the instruction-memory controller (MEM stage,
// RAM2 space). The requester is the master, the controller the slave.
interface imem_ctrl_if;
    import imem_ctrl_pkg::*;

    logic  dm_req;
    logic  dm_we;
    word_t dm_addr;
    word_t dm_wdata;
    word_t dm_rdata;
    logic  dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack
    );

endinterface

// File: rtl/imem_ctrl.sv
// Shares one async SRAM between instruction fetch and data-side accesses.
// Define IMEM_WRITE_EN to build the write states and the bus driver.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_FETCH  | SRAM serves pc_i; data request (if any) is accepted here
// ST_DM_RD  | data read (or ignored write) cycle, result latched at edge
// ST_DM_WR1 | write setup: address and data driven, we_n high
// ST_DM_WR2 | write pulse: we_n low
// ST_DM_WR3 | write hold: we_n high, address and data still driven
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  word_t             pc_i,
    output word_t             instr_o,
    output logic              stall_o,
    imem_ctrl_if.slave        dm,
    output logic [17:0]       ram_addr_o,
    inout  wire  [15:0]       ram_data_io,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    imem_state_e state_q, state_d;
    logic        dm_ack_q, dm_ack_d;
    word_t       dm_rdata_q, dm_rdata_d;
    logic        dm_start;
    logic        addr_dm;
`ifdef IMEM_WRITE_EN
    logic        ram_drive;
`endif

    // A request seen during its own ack cycle is the old one still held.
    assign dm_start = dm.dm_req & ~dm_ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            dm_ack_q   <= 1'b0;
            dm_rdata_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            dm_ack_q   <= dm_ack_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dm_ack_d   = 1'b0;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            ST_FETCH: begin
                if (dm_start) begin
`ifdef IMEM_WRITE_EN
                    state_d = dm.dm_we ? ST_DM_WR1 : ST_DM_RD;
`else
                    state_d = ST_DM_RD;
`endif
                end
            end
            ST_DM_RD: begin
                state_d  = ST_FETCH;
                dm_ack_d = 1'b1;
`ifdef IMEM_WRITE_EN
                dm_rdata_d = ram_data_io;
`else
                // Writes are completed as no-ops and must not disturb rdata.
                if (!dm.dm_we) begin
                    dm_rdata_d = ram_data_io;
                end
`endif
            end
`ifdef IMEM_WRITE_EN
            ST_DM_WR1: state_d = ST_DM_WR2;
            ST_DM_WR2: state_d = ST_DM_WR3;
            ST_DM_WR3: begin
                state_d  = ST_FETCH;
                dm_ack_d = 1'b1;
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes are gated by rst directly so a reset mid-write ends the pulse
    // and releases the bus without waiting for a clock edge.
    always_comb begin
        ram_ce_n_o = 1'b1;
        ram_oe_n_o = 1'b1;
        ram_we_n_o = 1'b1;
        addr_dm    = 1'b0;
`ifdef IMEM_WRITE_EN
        ram_drive  = 1'b0;
`endif
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    ram_ce_n_o = 1'b0;
                    ram_oe_n_o = 1'b0;
                end
                ST_DM_RD: begin
                    ram_ce_n_o = 1'b0;
                    addr_dm    = 1'b1;
`ifdef IMEM_WRITE_EN
                    ram_oe_n_o = 1'b0;
`else
                    ram_oe_n_o = dm.dm_we;
`endif
                end
`ifdef IMEM_WRITE_EN
                ST_DM_WR1: begin
                    ram_ce_n_o = 1'b0;
                    addr_dm    = 1'b1;
                    ram_drive  = 1'b1;
                end
                ST_DM_WR2: begin
                    ram_ce_n_o = 1'b0;
                    ram_we_n_o = 1'b0;
                    addr_dm    = 1'b1;
                    ram_drive  = 1'b1;
                end
                ST_DM_WR3: begin
                    ram_ce_n_o = 1'b0;
                    addr_dm    = 1'b1;
                    ram_drive  = 1'b1;
                end
`endif
                default: begin
                    ram_ce_n_o = 1'b1;
                end
            endcase
        end
    end

`ifdef IMEM_WRITE_EN
    assign ram_data_io = ram_drive ? dm.dm_wdata : 16'hzzzz;
`else
    assign ram_data_io = 16'hzzzz;
`endif

    assign ram_addr_o  = ram_addr_fmt(addr_dm ? dm.dm_addr : pc_i);
    assign stall_o     = rst | (state_q != ST_FETCH) | dm_start;
    assign instr_o     = stall_o ? NOP_INSTR : ram_data_io;
    assign dm.dm_ack   = dm_ack_q;
    assign dm.dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a behavioural async SRAM on the shared bus.
// Write-path steps are built only when IMEM_WRITE_EN is defined.
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        stall;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ce_n, oe_n, we_n;

    int n_tests = 0;
    int n_fail  = 0;
    int we_low_cnt = 0;

    logic [15:0] sram [0:1023];

    imem_ctrl_if dm_if();

    imem_ctrl #(.NOP_INSTR(16'h0800)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc),
        .instr_o     (instr),
        .stall_o     (stall),
        .dm          (dm_if),
        .ram_addr_o  (ram_addr),
        .ram_data_io (ram_data),
        .ram_ce_n_o  (ce_n),
        .ram_oe_n_o  (oe_n),
        .ram_we_n_o  (we_n)
    );

    always #5 clk = ~clk;

    assign ram_data = (ce_n === 1'b0 && oe_n === 1'b0) ? sram[ram_addr[9:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (we_n === 1'b0) begin
            we_low_cnt++;
            if (ce_n === 1'b0) sram[ram_addr[9:0]] <= ram_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        pc  = 16'h0000;
        dm_if.dm_req   = 1'b0;
        dm_if.dm_we    = 1'b0;
        dm_if.dm_addr  = 16'h0000;
        dm_if.dm_wdata = 16'h0000;
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
        sram[16'h0000] = 16'h4801;
        sram[16'h0010] = 16'h1111;
        sram[16'h0020] = 16'h2222;
        sram[16'h0100] = 16'hBEEF;
        sram[16'h0300] = 16'h5A5A;

        // held in reset
        step();
        chk("rst_stall", stall, 1);
        chk("rst_instr", instr, 16'h0800);
        chk("rst_ce_n", ce_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_ack", dm_if.dm_ack, 0);
        chk("rst_rdata", dm_if.dm_rdata, 16'h0000);

        // first fetch right after reset release
        rst = 1'b0;
        #1;
        chk("boot_instr", instr, 16'h4801);
        chk("boot_stall", stall, 0);
        chk("boot_ce_oe", {ce_n, oe_n, we_n}, 3'b001);
        chk("boot_addr", ram_addr, 18'h00000);

        // data read at 0x0100, request held through the ack cycle
        step();
        pc = 16'h0010;
        dm_if.dm_req  = 1'b1;
        dm_if.dm_we   = 1'b0;
        dm_if.dm_addr = 16'h0100;
        #1;
        chk("rd_req_stall", stall, 1);
        chk("rd_req_instr", instr, 16'h0800);
        step();
        chk("rd_st_stall", stall, 1);
        chk("rd_st_addr", ram_addr, 18'h00100);
        chk("rd_st_strobes", {ce_n, oe_n, we_n}, 3'b001);
        chk("rd_st_ack", dm_if.dm_ack, 0);
        step();
        chk("rd_ack", dm_if.dm_ack, 1);
        chk("rd_rdata", dm_if.dm_rdata, 16'hBEEF);
        chk("rd_ack_stall", stall, 0);
        chk("rd_ack_instr", instr, 16'h1111);
        chk("rd_ack_addr", ram_addr, 18'h00010);
        step();
        dm_if.dm_req = 1'b0;
        #1;
        chk("held_no_reentry", stall, 0);
        chk("held_ack_drop", dm_if.dm_ack, 0);
        chk("rdata_hold", dm_if.dm_rdata, 16'hBEEF);

        pc = 16'h0020;
        dm_if.dm_req   = 1'b1;
        dm_if.dm_we    = 1'b1;
`ifdef IMEM_WRITE_EN
        // write 0x1234 to 0x0200
        dm_if.dm_addr  = 16'h0200;
        dm_if.dm_wdata = 16'h1234;
        step();
        chk("wr1_strobes", {ce_n, oe_n, we_n}, 3'b011);
        chk("wr1_addr", ram_addr, 18'h00200);
        chk("wr1_bus", ram_data, 16'h1234);
        chk("wr1_stall", stall, 1);
        step();
        chk("wr2_strobes", {ce_n, oe_n, we_n}, 3'b010);
        chk("wr2_ack", dm_if.dm_ack, 0);
        step();
        chk("wr3_strobes", {ce_n, oe_n, we_n}, 3'b011);
        chk("wr3_ack", dm_if.dm_ack, 0);
        step();
        chk("wr_ack", dm_if.dm_ack, 1);
        chk("wr_ack_stall", stall, 0);
        chk("wr_rdata_keep", dm_if.dm_rdata, 16'hBEEF);
        step();
        dm_if.dm_req = 1'b0;
        #1;
        chk("wr_sram", sram[16'h0200], 16'h1234);
        chk("wr_we_low_cnt", we_low_cnt, 1);
        // read back
        dm_if.dm_req = 1'b1;
        dm_if.dm_we  = 1'b0;
        step();
        step();
        chk("rb_ack", dm_if.dm_ack, 1);
        chk("rb_rdata", dm_if.dm_rdata, 16'h1234);
        step();
        dm_if.dm_req = 1'b0;

        // reset during the write pulse abandons the write
        dm_if.dm_req   = 1'b1;
        dm_if.dm_we    = 1'b1;
        dm_if.dm_addr  = 16'h0210;
        dm_if.dm_wdata = 16'h7777;
        step();
        step();
        chk("abort_wr2_we", we_n, 0);
        rst = 1'b1;
        #1;
        chk("abort_strobes", {ce_n, oe_n, we_n}, 3'b111);
        chk("abort_stall", stall, 1);
        chk("abort_ack", dm_if.dm_ack, 0);
        dm_if.dm_req = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("abort_fetch_stall", stall, 0);
        chk("abort_fetch_instr", instr, 16'h2222);
        step();
        chk("abort_no_ack", dm_if.dm_ack, 0);
        chk("abort_sram", sram[16'h0210], 16'h0000);
`else
        // write request without the write path: read timing, no effect
        dm_if.dm_addr  = 16'h0300;
        dm_if.dm_wdata = 16'hDEAD;
        #1;
        chk("nw_req_stall", stall, 1);
        step();
        chk("nw_strobes", {ce_n, oe_n, we_n}, 3'b011);
        chk("nw_addr", ram_addr, 18'h00300);
        chk("nw_stall", stall, 1);
        chk("nw_st_ack", dm_if.dm_ack, 0);
        step();
        chk("nw_ack", dm_if.dm_ack, 1);
        chk("nw_rdata_keep", dm_if.dm_rdata, 16'hBEEF);
        chk("nw_ack_instr", instr, 16'h2222);
        step();
        dm_if.dm_req = 1'b0;
        #1;
        chk("nw_ack_drop", dm_if.dm_ack, 0);
        chk("nw_sram", sram[16'h0300], 16'h5A5A);
        chk("nw_we_low_cnt", we_low_cnt, 0);
`endif

        // asynchronous reset clears the read data register
        rst = 1'b1;
        #1;
        chk("final_rst_rdata", dm_if.dm_rdata, 16'h0000);
        chk("final_rst_instr", instr, 16'h0800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter NOP_INSTR, default 16'h0800, is the bubble instruction driven when no valid fetch exists.
REQ-002 CLK  input  1  single clock; all state updates on posedge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 pc_i  input  16  fetch address from the fetch stage.
REQ-005 instr_o  output  16  instruction at pc_i, to the fetch-stage instr_i and IF/ID.
REQ-006 stall_o  output  1  drives the fetch-stage stall_pc_i.
REQ-007 dm_req_i  input  1  data-side access request (MEM stage, RAM2 space).
REQ-008 dm_we_i  input  1  1 = write, 0 = read; valid with dm_req_i.
REQ-009 dm_addr_i  input  16  data-side word address.
REQ-010 dm_wdata_i  input  16  data-side write data.
REQ-011 dm_rdata_o  output  16  registered read data.
REQ-012 dm_ack_o  output  1  one-cycle completion pulse.
REQ-013 ram_addr_o  output  18  SRAM address, always {2'b00, 16-bit address}.
REQ-014 ram_data_io  inout  16  SRAM data bus.
REQ-015 ram_ce_n_o, ram_oe_n_o, ram_we_n_o  output  1 each  SRAM strobes, active-low.

Function
REQ-016 FSM states: FETCH, DM_RD, DM_WR1, DM_WR2, DM_WR3.
REQ-017 FETCH: ram_addr_o from pc_i, ce_n=0, oe_n=0, we_n=1, bus hi-Z; instr_o = ram_data_io combinationally when stall_o=0.
REQ-018 stall_o = (state != FETCH) | (dm_req_i & ~dm_ack_o); combinational.
REQ-019 instr_o = NOP_INSTR whenever stall_o=1.
REQ-020 In FETCH, dm_req_i & ~dm_ack_o at posedge: next state DM_RD if dm_we_i=0, DM_WR1 if dm_we_i=1; otherwise stay FETCH.
REQ-021 dm_req_i is ignored while dm_ack_o=1, so a held request cannot retrigger.
REQ-022 DM_RD: address from dm_addr_i, oe_n=0; at posedge dm_rdata_o <= ram_data_io, dm_ack_o <= 1, next FETCH (read latency 1 cycle).
REQ-023 DM_WR1: address from dm_addr_i, bus driven with dm_wdata_i, oe_n=1, we_n=1.
REQ-024 DM_WR2: as DM_WR1 but we_n=0.
REQ-025 DM_WR3: we_n=1, address and data still driven; at posedge dm_ack_o <= 1, next FETCH (write latency 3 cycles).
REQ-026 Requester holds dm_addr_i/dm_wdata_i/dm_we_i stable from request until ack.
REQ-027 dm_ack_o is high for exactly one cycle, the first FETCH cycle after completion.
REQ-028 Bus driven only in DM_WR1..DM_WR3; oe_n and we_n are never both 0.
REQ-029 dm_rdata_o holds its last value until the next read completes.

Reset
REQ-030 On RST: state FETCH, dm_ack_o=0, dm_rdata_o=16'h0000, asynchronously.
REQ-031 While RST=1: ce_n=oe_n=we_n=1, bus hi-Z, stall_o=1, instr_o=NOP_INSTR.
REQ-032 RST mid-write forces we_n=1 and releases the bus immediately; the write is abandoned with no ack.

Configuration
REQ-033 Macro IMEM_WRITE_EN compiles in DM_WR1..DM_WR3 and bus driving.
REQ-034 Without IMEM_WRITE_EN: a write request goes to DM_RD timing with oe_n=1, we_n=1, bus hi-Z; ack after 1 cycle; SRAM unchanged; dm_rdata_o unchanged.

Structure
REQ-035 State encodings and NOP_INSTR default live in the shared CPU defines header.
REQ-036 No sub-module; a single flat module with one FSM register and output decode.

Verification
REQ-037 Reset release, SRAM[0x0000]=16'h4801, pc_i=0 -> instr_o=16'h4801, stall_o=0 first cycle after RST falls.
REQ-038 Read: dm_req_i=1, we=0, addr=16'h0100, SRAM=16'hBEEF -> stall_o=1 two cycles, dm_rdata_o=16'hBEEF, dm_ack_o one pulse, fetch resumes at unchanged pc.
REQ-039 Write (IMEM_WRITE_EN): addr=16'h0200, data=16'h1234 -> we_n low only in DM_WR2, ack after 3 cycles, readback 16'h1234.
REQ-040 Held request: dm_req_i kept high through ack -> exactly one access, no second FSM entry.
REQ-041 RST asserted in DM_WR2 -> we_n=1 and bus hi-Z same cycle, no ack, state FETCH.
REQ-042 Without IMEM_WRITE_EN: write to 16'h0300 -> ack after 1 cycle, SRAM[0x0300] unchanged, we_n never 0.
